block_spawn_sched: RTL

BLOCK_SPAWN_SCHED -- requirements
Module: block_spawn_sched

---
 rtl/bnw_pkg.sv | 23 ++
 rtl/block_spawn_sched_if.sv | 22 ++
 rtl/note_chart_rom.sv | 21 ++
 rtl/block_spawn_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bnw_pkg.sv
// Shared types and chart constants for the falling-block spawn scheduler.
package bnw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int NUM_LANES = 4;

   localparam logic [NUM_LANES-1:0] MASK_NONE   = 4'b0000;
   localparam logic [NUM_LANES-1:0] MASK_SINGLE = 4'b0100;
   localparam logic [NUM_LANES-1:0] MASK_DOUBLE = 4'b1001;

   function automatic logic [1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
      lowest_lane = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (m[i]) lowest_lane = 2'(i);
      end
   endfunction

endpackage

// File: rtl/block_spawn_sched_if.sv
// Spawn/slot bus between the scheduler and the falling-block slot array.
interface block_spawn_sched_if #(
   parameter int NUM_SLOTS = 8
);
   // spawn_valid is a one-cycle pulse with no ready: the addressed slot is
   // guaranteed free, so spawn_lane/spawn_slot are consumed on that cycle.
   logic                 spawn_valid;
   logic [1:0]           spawn_lane;
   logic [2:0]           spawn_slot;
   logic [NUM_SLOTS-1:0] slot_busy;
   logic [NUM_SLOTS-1:0] slot_done;

   modport master (
      output spawn_valid, spawn_lane, spawn_slot, slot_busy,
      input  slot_done
   );

   modport slave (
      input  spawn_valid, spawn_lane, spawn_slot, slot_busy,
      output slot_done
   );
endinterface

// File: rtl/note_chart_rom.sv
// Combinational chart: lane mask for a (level, beat) pair.
module note_chart_rom
   import bnw_pkg::*;
(
   input  logic [1:0]           level,
   input  logic [6:0]           beat_cnt,
   output logic [NUM_LANES-1:0] mask
);

   always_comb begin
      mask = MASK_NONE;
      if (level == 2'd0) begin
         case (beat_cnt)
            7'd11, 7'd17, 7'd41, 7'd53, 7'd65, 7'd77: mask = MASK_SINGLE;
            7'd20:                                    mask = MASK_DOUBLE;
            default:                                  mask = MASK_NONE;
         endcase
      end
   end

endmodule

// File: rtl/block_spawn_sched.sv
// Beat-driven spawn scheduler: chart lanes -> pending mask -> lane FIFO -> free slot.
// Optional SPAWN_DROP_CNT_EN: lanes meeting a full FIFO are dropped and counted.
module block_spawn_sched
   import bnw_pkg::*;
#(
   parameter int NUM_SLOTS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       stop_or_endgame,
   input  logic [1:0] level,
   input  logic [6:0] beat_cnt,
   block_spawn_sched_if.master bus,
`ifdef SPAWN_DROP_CNT_EN
   output logic [7:0] drop_cnt,
`endif
   output state_t     fsm_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   state_t                 state;
   logic [6:0]             pre_beat_cnt;
   logic [1:0]             level_q;
   logic [NUM_LANES-1:0]   pending;
   logic [1:0]             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt;
   logic [NUM_SLOTS-1:0]   slot_busy_q;
   logic                   spawn_valid_q;
   logic [1:0]             spawn_lane_q;
   logic [2:0]             spawn_slot_q;

   logic                   run, beat_add, fifo_full, fifo_empty;
   logic                   do_push, do_pop, take_pending, any_free;
   logic [NUM_LANES-1:0]   chart_mask, pend_clr, pending_next;
   logic [1:0]             pend_lane;
   logic [2:0]             alloc_idx;
   logic [NUM_SLOTS-1:0]   alloc_set;
`ifdef SPAWN_DROP_CNT_EN
   logic                   do_drop;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   note_chart_rom u_chart (
      .level    (level_q),
      .beat_cnt (beat_cnt),
      .mask     (chart_mask)
   );

   // A drop in beat_cnt is a song wrap, not a new beat.
   assign beat_add   = (beat_cnt > pre_beat_cnt);
   assign run        = (state == ST_RUN);
   assign fifo_full  = (fifo_cnt == FULL_CNT);
   assign fifo_empty = (fifo_cnt == '0);
   assign pend_lane  = lowest_lane(pending);
   assign pend_clr   = NUM_LANES'(1) << pend_lane;
   assign do_push    = run && (|pending) && !fifo_full;
   assign do_pop     = run && !fifo_empty && any_free;
`ifdef SPAWN_DROP_CNT_EN
   assign do_drop      = run && (|pending) && fifo_full;
   assign take_pending = do_push || do_drop;
`else
   assign take_pending = do_push;
`endif

   always_comb begin
      alloc_idx = '0;
      any_free  = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slot_busy_q[i]) begin
            alloc_idx = 3'(i);
            any_free  = 1'b1;
         end
      end
   end

   assign alloc_set    = do_pop ? (NUM_SLOTS'(1) << alloc_idx) : '0;
   assign pending_next = (pending & ~(take_pending ? pend_clr : '0))
                       | ((run && beat_add) ? chart_mask : '0);

   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr] <= pend_lane;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         pre_beat_cnt  <= '0;
         level_q       <= '0;
         pending       <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         slot_busy_q   <= '0;
         spawn_valid_q <= 1'b0;
         spawn_lane_q  <= '0;
         spawn_slot_q  <= '0;
`ifdef SPAWN_DROP_CNT_EN
         drop_cnt      <= '0;
`endif
      end else if (restart) begin
         state         <= ST_IDLE;
         pre_beat_cnt  <= '0;
         level_q       <= '0;
         pending       <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         slot_busy_q   <= '0;
         spawn_valid_q <= 1'b0;
         spawn_lane_q  <= '0;
         spawn_slot_q  <= '0;
`ifdef SPAWN_DROP_CNT_EN
         drop_cnt      <= '0;
`endif
      end else begin
         pre_beat_cnt  <= beat_cnt;
         pending       <= pending_next;
         spawn_valid_q <= 1'b0;
         slot_busy_q   <= (slot_busy_q & ~bus.slot_done) | alloc_set;

         case (state)
            ST_IDLE: if (!stop_or_endgame) begin
               state   <= ST_RUN;
               level_q <= level;
            end
            ST_RUN:  if (stop_or_endgame)  state <= ST_HOLD;
            ST_HOLD: if (!stop_or_endgame) state <= ST_RUN;
            default: state <= ST_IDLE;
         endcase

         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop) begin
            rd_ptr        <= ptr_inc(rd_ptr);
            spawn_valid_q <= 1'b1;
            spawn_lane_q  <= fifo_mem[rd_ptr];
            spawn_slot_q  <= alloc_idx;
         end

         case ({do_push, do_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

`ifdef SPAWN_DROP_CNT_EN
         if (do_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
`endif
      end
   end

   assign bus.spawn_valid = spawn_valid_q;
   assign bus.spawn_lane  = spawn_lane_q;
   assign bus.spawn_slot  = spawn_slot_q;
   assign bus.slot_busy   = slot_busy_q;
   assign fsm_state       = state;

endmodule
